// File: rtl/shifter_pkg.sv
// Shared widths and the request record exchanged between producers,
// the request scheduler and its FIFO.
package shifter_pkg;

  localparam int SR_N     = 3;
  localparam int SR_W     = 2 ** SR_N;
  localparam int SR_DEPTH = 4;
  localparam int SR_CNT_W = $clog2(SR_DEPTH + 1);

  typedef struct packed {
    logic [SR_W-1:0] a;
    logic [SR_N-1:0] amt;
    logic            lr;
  } shift_req_t;

endpackage

// File: rtl/shift_req_fifo.sv
// Small synchronous FIFO of shift requests; head entry is visible
// combinationally so the issue stage can register it directly.
module shift_req_fifo
  import shifter_pkg::*;
#(
  parameter int DEPTH = SR_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           push,
  input  shift_req_t                     push_data,
  input  logic                           pop,
  output shift_req_t                     pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  shift_req_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_next;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Guards make the FIFO self-protecting even if a caller misbehaves.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage has no reset so it maps onto plain RAM/register resources.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/shift_req_scheduler.sv
// Request front-end for the barrel shifter: FIFO -> ISS (registered sh_*)
// -> RES (captured sh_y on a valid/ready output with back-pressure).
module shift_req_scheduler
  import shifter_pkg::*;
#(
  parameter int N     = SR_N,
  parameter int DEPTH = SR_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2**N-1:0]                in_a,
  input  logic [N-1:0]                   in_amt,
  input  logic                           in_lr,
  output logic [2**N-1:0]                sh_a,
  output logic [N-1:0]                   sh_amt,
  output logic                           sh_lr,
  input  logic [2**N-1:0]                sh_y,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2**N-1:0]                out_y,
  output logic [N-1:0]                   out_amt,
  output logic                           out_lr,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  localparam int W     = 2 ** N;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             r_in_ready;
  logic             r_iss_v;
  logic [W-1:0]     r_sh_a;
  logic [N-1:0]     r_sh_amt;
  logic             r_sh_lr;
  logic             r_out_valid;
  logic [W-1:0]     r_out_y;
  logic [N-1:0]     r_out_amt;
  logic             r_out_lr;

  logic             w_res_en;
  logic             w_iss_en;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;
  shift_req_t       w_push_req;
  shift_req_t       w_head;

  assign w_res_en = !r_out_valid || out_ready;
  assign w_iss_en = !r_iss_v || w_res_en;

  // in_ready is registered, so a full FIFO refuses a push even on a pop cycle.
  assign w_push = in_valid && r_in_ready && !w_full && !flush;
  assign w_pop  = w_iss_en && !w_empty && !flush;

  assign w_push_req = shift_req_t'{a: in_a, amt: in_amt, lr: in_lr};

  always_comb begin
    w_count_next = w_count;
    if (flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = w_count + CNT_W'(1);
        2'b01:   w_count_next = w_count - CNT_W'(1);
        default: w_count_next = w_count;
      endcase
    end
  end

  shift_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_push_req),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready  <= 1'b0;
      r_iss_v     <= 1'b0;
      r_sh_a      <= '0;
      r_sh_amt    <= '0;
      r_sh_lr     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_amt   <= '0;
      r_out_lr    <= 1'b0;
    end else begin
      r_in_ready <= (w_count_next < CNT_W'(DEPTH));
      if (flush) begin
        // Data registers keep their contents; only the valid bits drop.
        r_iss_v     <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_res_en) begin
          r_out_valid <= r_iss_v;
          if (r_iss_v) begin
            r_out_y   <= sh_y;
            r_out_amt <= r_sh_amt;
            r_out_lr  <= r_sh_lr;
          end
        end
        if (w_iss_en) begin
          r_iss_v <= !w_empty;
          if (!w_empty) begin
            r_sh_a   <= w_head.a;
            r_sh_amt <= w_head.amt;
            r_sh_lr  <= w_head.lr;
          end
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign sh_a       = r_sh_a;
  assign sh_amt     = r_sh_amt;
  assign sh_lr      = r_sh_lr;
  assign out_valid  = r_out_valid;
  assign out_y      = r_out_y;
  assign out_amt    = r_out_amt;
  assign out_lr     = r_out_lr;
  assign fifo_count = w_count;

endmodule
